// File: rtl/multicycle_ctrl_pkg.sv
// Shared constants for the multi-cycle MIPS-subset controller: state codes,
// datapath mux encodings, opcode/funct values and instruction-class helpers.
package multicycle_ctrl_pkg;

    typedef enum logic [3:0] {
        S_FETCH  = 4'd0,
        S_DECODE = 4'd1,
        S_EXEC   = 4'd2,
        S_ALUWB  = 4'd3,
        S_ADDR   = 4'd4,
        S_MEM    = 4'd5,
        S_LDWB   = 4'd6,
        S_BRANCH = 4'd7,
        S_JUMP   = 4'd8
    } state_t;

    localparam logic [2:0] ALU_ADD = 3'd0;
    localparam logic [2:0] ALU_SUB = 3'd1;
    localparam logic [2:0] ALU_OR  = 3'd2;
    localparam logic [2:0] ALU_LUI = 3'd3;

    localparam logic [1:0] A3SEL_RT = 2'd0;
    localparam logic [1:0] A3SEL_RD = 2'd1;
    localparam logic [1:0] A3SEL_RA = 2'd2;

    localparam logic [1:0] WDSEL_ALUANS = 2'd0;
    localparam logic [1:0] WDSEL_DMRD   = 2'd1;
    localparam logic [1:0] WDSEL_PCA4   = 2'd2;

    localparam logic [1:0] PCSEL_PCA4   = 2'd0;
    localparam logic [1:0] PCSEL_BRANCH = 2'd1;
    localparam logic [1:0] PCSEL_J      = 2'd2;
    localparam logic [1:0] PCSEL_JR     = 2'd3;

    localparam logic [1:0] DM_WORD = 2'd0;
    localparam logic [1:0] DM_BYTE = 2'd1;
    localparam logic [1:0] DM_HALF = 2'd2;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_JAL   = 6'h03;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_ORI   = 6'h0D;
    localparam logic [5:0] OP_LUI   = 6'h0F;
    localparam logic [5:0] OP_LB    = 6'h20;
    localparam logic [5:0] OP_LH    = 6'h21;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SB    = 6'h28;
    localparam logic [5:0] OP_SH    = 6'h29;
    localparam logic [5:0] OP_SW    = 6'h2B;

    localparam logic [5:0] FN_JR  = 6'h08;
    localparam logic [5:0] FN_ADD = 6'h20;
    localparam logic [5:0] FN_SUB = 6'h22;

    // One-hot instruction class; all zero means unknown instruction
    typedef struct packed {
        logic add;
        logic sub;
        logic ori;
        logic lui;
        logic lw;
        logic lb;
        logic lh;
        logic sw;
        logic sb;
        logic sh;
        logic beq;
        logic j;
        logic jal;
        logic jr;
    } instr_class_t;

    function automatic logic is_alu(input instr_class_t c);
        return c.add | c.sub | c.ori | c.lui;
    endfunction

    function automatic logic is_store(input instr_class_t c);
        return c.sw | c.sb | c.sh;
    endfunction

    function automatic logic is_mem(input instr_class_t c);
        return c.lw | c.lb | c.lh | is_store(c);
    endfunction

    function automatic logic is_jump(input instr_class_t c);
        return c.j | c.jal | c.jr;
    endfunction

    function automatic logic [2:0] alu_op(input instr_class_t c);
        logic [2:0] op;
        op = ALU_ADD;
        if (c.sub) op = ALU_SUB;
        if (c.ori) op = ALU_OR;
        if (c.lui) op = ALU_LUI;
        return op;
    endfunction

    function automatic logic [1:0] dm_width(input instr_class_t c);
        logic [1:0] w;
        w = DM_WORD;
        if (c.lb | c.sb) w = DM_BYTE;
        if (c.lh | c.sh) w = DM_HALF;
        return w;
    endfunction

endpackage

// File: rtl/multicycle_ctrl_decode.sv
// mc_decode: maps opcode/funct to a one-hot instruction class.
module mc_decode
    import multicycle_ctrl_pkg::*;
(
    input  logic [5:0]   i_opcode,
    input  logic [5:0]   i_funct,
    output instr_class_t o_cls
);

    logic w_rtype;
    assign w_rtype = (i_opcode == OP_RTYPE);

    // Pure opcode/funct compare; R-type with an unrecognised funct leaves every bit clear
    always_comb begin
        o_cls     = '0;
        o_cls.add = w_rtype && (i_funct == FN_ADD);
        o_cls.sub = w_rtype && (i_funct == FN_SUB);
        o_cls.jr  = w_rtype && (i_funct == FN_JR);
        o_cls.ori = (i_opcode == OP_ORI);
        o_cls.lui = (i_opcode == OP_LUI);
        o_cls.lw  = (i_opcode == OP_LW);
        o_cls.lb  = (i_opcode == OP_LB);
        o_cls.lh  = (i_opcode == OP_LH);
        o_cls.sw  = (i_opcode == OP_SW);
        o_cls.sb  = (i_opcode == OP_SB);
        o_cls.sh  = (i_opcode == OP_SH);
        o_cls.beq = (i_opcode == OP_BEQ);
        o_cls.j   = (i_opcode == OP_J);
        o_cls.jal = (i_opcode == OP_JAL);
    end

endmodule

// File: rtl/multicycle_ctrl.sv
// Multi-cycle control FSM: sequences FETCH/DECODE/EXEC/MEM/WB for the shared
// datapath and handshakes with wait-state capable instruction/data memories.
module multicycle_ctrl
    import multicycle_ctrl_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic [5:0] opcode,
    input  logic [5:0] funct,
    input  logic       ALUflag_zero,
    output logic       imem_req,
    input  logic       imem_ack,
    output logic       dmem_req,
    input  logic       dmem_ack,
    output logic       IRWrite,
    output logic       PCWrite,
    output logic       RegWrite,
    output logic       MemWrite,
    output logic [1:0] A3Sel,
    output logic [2:0] ALUOp,
    output logic       ALUBSel,
    output logic [1:0] WDSel,
    output logic [1:0] PCSel,
    output logic       EXTOp,
    output logic [1:0] DMOp,
    output logic       instr_done,
    output logic [3:0] state
);

    state_t       r_state;
    state_t       w_state_next;
    instr_class_t w_cls;

    mc_decode u_decode (
        .i_opcode (opcode),
        .i_funct  (funct),
        .o_cls    (w_cls)
    );

    assign state = r_state;

    // State register; reset low forces FETCH immediately
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) r_state <= S_FETCH;
        else        r_state <= w_state_next;
    end

    // Next state and Mealy outputs; everything is forced to 0 while reset is low
    always_comb begin
        w_state_next = S_FETCH;
        imem_req     = 1'b0;
        dmem_req     = 1'b0;
        IRWrite      = 1'b0;
        PCWrite      = 1'b0;
        RegWrite     = 1'b0;
        MemWrite     = 1'b0;
        A3Sel        = A3SEL_RT;
        ALUOp        = ALU_ADD;
        ALUBSel      = 1'b0;
        WDSel        = WDSEL_ALUANS;
        PCSel        = PCSEL_PCA4;
        EXTOp        = 1'b0;
        DMOp         = DM_WORD;
        instr_done   = 1'b0;
        if (reset) begin
            case (r_state)
                S_FETCH: begin
                    imem_req = 1'b1;
                    if (imem_ack) begin
                        IRWrite      = 1'b1;
                        w_state_next = S_DECODE;
                    end else begin
                        w_state_next = S_FETCH;
                    end
                end
                S_DECODE: begin
                    if (is_alu(w_cls))       w_state_next = S_EXEC;
                    else if (is_mem(w_cls))  w_state_next = S_ADDR;
                    else if (w_cls.beq)      w_state_next = S_BRANCH;
                    else if (is_jump(w_cls)) w_state_next = S_JUMP;
                    else begin
                        // Unknown instruction: skip it by advancing PC
                        PCWrite    = 1'b1;
                        instr_done = 1'b1;
                    end
                end
                S_EXEC: begin
                    ALUOp        = alu_op(w_cls);
                    ALUBSel      = w_cls.ori | w_cls.lui;
                    w_state_next = S_ALUWB;
                end
                S_ALUWB: begin
                    ALUOp      = alu_op(w_cls);
                    ALUBSel    = w_cls.ori | w_cls.lui;
                    RegWrite   = 1'b1;
                    WDSel      = WDSEL_ALUANS;
                    A3Sel      = (w_cls.add | w_cls.sub) ? A3SEL_RD : A3SEL_RT;
                    PCWrite    = 1'b1;
                    instr_done = 1'b1;
                end
                S_ADDR: begin
                    ALUOp        = ALU_ADD;
                    ALUBSel      = 1'b1;
                    EXTOp        = 1'b1;
                    w_state_next = S_MEM;
                end
                S_MEM: begin
                    // Address and request stay stable for the whole wait period
                    ALUOp    = ALU_ADD;
                    ALUBSel  = 1'b1;
                    EXTOp    = 1'b1;
                    dmem_req = 1'b1;
                    MemWrite = is_store(w_cls);
                    DMOp     = dm_width(w_cls);
                    if (!dmem_ack) begin
                        w_state_next = S_MEM;
                    end else if (is_store(w_cls)) begin
                        PCWrite    = 1'b1;
                        instr_done = 1'b1;
                    end else begin
                        w_state_next = S_LDWB;
                    end
                end
                S_LDWB: begin
                    RegWrite   = 1'b1;
                    A3Sel      = A3SEL_RT;
                    WDSel      = WDSEL_DMRD;
                    DMOp       = dm_width(w_cls);
                    PCWrite    = 1'b1;
                    instr_done = 1'b1;
                end
                S_BRANCH: begin
                    ALUOp      = ALU_SUB;
                    PCWrite    = 1'b1;
                    PCSel      = ALUflag_zero ? PCSEL_BRANCH : PCSEL_PCA4;
                    instr_done = 1'b1;
                end
                S_JUMP: begin
                    PCWrite    = 1'b1;
                    PCSel      = w_cls.jr ? PCSEL_JR : PCSEL_J;
                    instr_done = 1'b1;
                    if (w_cls.jal) begin
                        RegWrite = 1'b1;
                        A3Sel    = A3SEL_RA;
                        WDSel    = WDSEL_PCA4;
                    end
                end
                default: w_state_next = S_FETCH;
            endcase
        end
    end

endmodule
